// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V front end.
package riscv_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a time
// and presents {instr, pc, pc+4} to decode through a registered valid/ready slot.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  PCSrc_i,
  input  logic [ADDR_WIDTH-1:0] PCTarget_i,
  output logic [DATA_WIDTH-1:0] Instr_o,
  output logic [ADDR_WIDTH-1:0] PC_o,
  output logic [ADDR_WIDTH-1:0] PCPlus4_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic                  misalign_o
);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] target_aligned;
  logic                  kill_q;
  logic                  slot_free;
  logic                  load_slot;

  assign pc_plus4       = pc_q + ADDR_WIDTH'(4);
  assign target_aligned = {PCTarget_i[ADDR_WIDTH-1:2], 2'b00};

  // State, PC, kill flag and IF/ID slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      instr_valid_o <= 1'b0;
      Instr_o       <= DATA_WIDTH'(NOP_INSTR);
      PC_o          <= '0;
      PCPlus4_o     <= '0;
      misalign_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_o <= PCSrc_i && (PCTarget_i[1:0] != 2'b00);
      if (PCSrc_i) begin
        // Flush the slot; an in-flight response with no rvalid yet must be dropped later.
        pc_q          <= target_aligned;
        instr_valid_o <= 1'b0;
        kill_q        <= (state_q == WAIT) && !imem_rvalid_i;
      end else begin
        if ((state_q == WAIT) && imem_rvalid_i) begin
          kill_q <= 1'b0;
        end
        if (load_slot) begin
          Instr_o       <= imem_rdata_i;
          PC_o          <= pc_q;
          PCPlus4_o     <= pc_plus4;
          instr_valid_o <= 1'b1;
          pc_q          <= pc_plus4;
        end else if (instr_valid_o && instr_ready_i) begin
          instr_valid_o <= 1'b0;
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    load_slot = 1'b0;
    case (state_q)
      IDLE: begin
        if (imem_req_o) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          state_d   = IDLE;
          load_slot = !kill_q && !PCSrc_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request issue: only from IDLE, only into a free slot, never in a redirect cycle.
  always_comb begin
    slot_free   = !instr_valid_o || instr_ready_i;
    imem_req_o  = rst_n && (state_q == IDLE) && slot_free && !PCSrc_i;
    imem_addr_o = pc_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        PCSrc_i;
  logic [31:0] PCTarget_i;
  logic [31:0] Instr_o;
  logic [31:0] PC_o;
  logic [31:0] PCPlus4_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        misalign_o;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .PCSrc_i       (PCSrc_i),
    .PCTarget_i    (PCTarget_i),
    .Instr_o       (Instr_o),
    .PC_o          (PC_o),
    .PCPlus4_o     (PCPlus4_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .misalign_o    (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Move to the next negedge with all single-cycle strobes cleared.
  task automatic next_cycle();
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    PCSrc_i       = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    PCSrc_i       = 1'b0;
    PCTarget_i    = '0;
    instr_ready_i = 1'b1;

    // 1: reset state, then first request on release
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", Instr_o, 32'h0000_0013);
    chk("rst_pc", PC_o, 32'h0);
    chk("rst_pc4", PCPlus4_o, 32'h0);
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_mis", 32'(misalign_o), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("first_req", 32'(imem_req_o), 32'd1);
    chk("first_addr", imem_addr_o, 32'h0);

    // 2: sequential fetch, latency 1
    next_cycle();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0050_0093;
    #1;
    chk("wait_noreq", 32'(imem_req_o), 32'd0);
    next_cycle();
    #1;
    chk("seq_valid", 32'(instr_valid_o), 32'd1);
    chk("seq_instr", Instr_o, 32'h0050_0093);
    chk("seq_pc", PC_o, 32'h0);
    chk("seq_pc4", PCPlus4_o, 32'h4);
    chk("seq_req", 32'(imem_req_o), 32'd1);
    chk("seq_addr", imem_addr_o, 32'h4);
    next_cycle();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h00a0_0113;

    // 3: decode stall for 3 cycles
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      instr_ready_i = 1'b0;
      #1;
      chk("stall_valid", 32'(instr_valid_o), 32'd1);
      chk("stall_instr", Instr_o, 32'h00a0_0113);
      chk("stall_pc", PC_o, 32'h4);
      chk("stall_pc4", PCPlus4_o, 32'h8);
      chk("stall_req", 32'(imem_req_o), 32'd0);
    end
    instr_ready_i = 1'b1;
    #1;
    chk("unstall_req", 32'(imem_req_o), 32'd1);
    chk("unstall_addr", imem_addr_o, 32'h8);

    // 4: redirect while waiting, response arrives late and is dropped
    next_cycle();
    PCSrc_i    = 1'b1;
    PCTarget_i = 32'h100;
    #1;
    chk("redir_noreq", 32'(imem_req_o), 32'd0);
    next_cycle();
    #1;
    chk("kill_valid", 32'(instr_valid_o), 32'd0);
    chk("kill_noreq", 32'(imem_req_o), 32'd0);
    next_cycle();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hdead_beef;
    next_cycle();
    #1;
    chk("late_drop_valid", 32'(instr_valid_o), 32'd0);
    chk("tgt_req", 32'(imem_req_o), 32'd1);
    chk("tgt_addr", imem_addr_o, 32'h100);

    // 5: redirect coincident with rvalid
    next_cycle();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h1111_1111;
    PCSrc_i       = 1'b1;
    PCTarget_i    = 32'h200;
    next_cycle();
    #1;
    chk("coin_valid", 32'(instr_valid_o), 32'd0);
    chk("coin_req", 32'(imem_req_o), 32'd1);
    chk("coin_addr", imem_addr_o, 32'h200);
    chk("coin_mis", 32'(misalign_o), 32'd0);

    // 6: misaligned target
    next_cycle();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h2222_2222;
    PCSrc_i       = 1'b1;
    PCTarget_i    = 32'h102;
    next_cycle();
    #1;
    chk("mis_pulse", 32'(misalign_o), 32'd1);
    chk("mis_addr", imem_addr_o, 32'h100);
    chk("mis_req", 32'(imem_req_o), 32'd1);
    next_cycle();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0000_0033;
    #1;
    chk("mis_clear", 32'(misalign_o), 32'd0);
    next_cycle();
    #1;
    chk("mis_instr", Instr_o, 32'h0000_0033);
    chk("mis_pc", PC_o, 32'h100);
    chk("mis_pc4", PCPlus4_o, 32'h104);
    chk("mis_next_addr", imem_addr_o, 32'h104);

    // PC+4 wraps at the top of the address space
    next_cycle();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h5555_5555;
    PCSrc_i       = 1'b1;
    PCTarget_i    = 32'hffff_fffc;
    next_cycle();
    #1;
    chk("wrap_req_addr", imem_addr_o, 32'hffff_fffc);
    next_cycle();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0000_0093;
    next_cycle();
    #1;
    chk("wrap_pc", PC_o, 32'hffff_fffc);
    chk("wrap_pc4", PCPlus4_o, 32'h0);
    chk("wrap_next_addr", imem_addr_o, 32'h0);

    // 7: async reset in the middle of WAIT
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid_o), 32'd0);
    chk("arst_instr", Instr_o, 32'h0000_0013);
    chk("arst_pc", PC_o, 32'h0);
    chk("arst_req", 32'(imem_req_o), 32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hbad0_bad0;
    #1;
    chk("post_rst_req", 32'(imem_req_o), 32'd1);
    chk("post_rst_addr", imem_addr_o, 32'h0);
    next_cycle();
    #1;
    chk("stray_valid", 32'(instr_valid_o), 32'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0010_0093;
    next_cycle();
    #1;
    chk("post_rst_instr", Instr_o, 32'h0010_0093);
    chk("post_rst_pc", PC_o, 32'h0);
    chk("post_rst_valid", 32'(instr_valid_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
